// File: rtl/rbs_serial_sub.sv
// rbs_serial_sub: bit-serial ripple-borrow subtractor.
//
// Captures a minuend, a subtrahend and a borrow-in on a start strobe. It then
// resolves one difference bit per clock, LSB first, through a single
// full-subtractor cell and a registered borrow. The difference and the
// borrow-out are published together with a one-cycle done pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   start      in   request a subtraction; honoured only when idle
//   a          in   [WIDTH-1:0] minuend, sampled at acceptance
//   b          in   [WIDTH-1:0] subtrahend, sampled at acceptance
//   bin        in   borrow-in, sampled at acceptance
//   busy       out  high while an operation is in flight
//   done       out  one-cycle completion pulse
//   diff       out  [WIDTH-1:0] (a - b - bin) mod 2^WIDTH, held until next completion
//   bout       out  borrow-out, 1 iff a < b + bin, held like diff
//   state_dbg  out  current FSM state (0 = IDLE, 1 = RUN), for observation only
//
// Handshake: start is a request with no backpressure signal of its own. It is
// accepted on a rising edge only while busy is low; a start seen while busy is
// high is dropped. done marks the one cycle in which a new diff/bout appears.
module rbs_serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  // Full-subtractor cell on the current LSBs and the running borrow.
  logic             x_bit;
  logic             y_bit;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  assign x_bit = a_q[0];
  assign y_bit = b_q[0];
  assign d_bit = x_bit ^ y_bit ^ br_q;
  assign br_d  = (~x_bit & y_bit) | (~x_bit & br_q) | (y_bit & br_q);
  // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_d = {d_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          // Publish only the completed word; diff/bout never show partials.
          if (cnt_q == LAST_BIT) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign state_dbg = logic'(state_q);

endmodule
